// File: rtl/pio_switch_led_ctrl.sv
// Switch-input / LED-output Avalon-MM peripheral: per-channel sync + debounce
// lanes, maskable edge capture, and static/blink LED drive.

module pio_switch_led_ctrl_chan #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic edge_evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2, deb, deb_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            deb_d <= deb;
            // Counter only runs while the synced level disagrees with the accepted one
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    logic rise, fall;
    assign rise     = deb & ~deb_d;
    assign fall     = ~deb & deb_d;
    assign level    = deb;
    assign edge_evt = (EDGE_MODE == 0) ? rise :
                      (EDGE_MODE == 1) ? fall : (rise | fall);
endmodule

module pio_switch_led_ctrl #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_DIV       = 25000000,
    parameter int EDGE_MODE       = 2
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [CHANNELS-1:0] switches_export,
    output logic [CHANNELS-1:0] leds_export,
    input  logic [2:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq
);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CHANNELS-1:0] level, edge_evt;
    logic [CHANNELS-1:0] edge_r, mask_r, led_r, mode_r;
    logic [CHANNELS-1:0] wdata, edge_clr, rmux;
    logic [31:0]         rd_next;
    logic [BW-1:0]       blink_cnt;
    logic                phase;
    logic                unused_wdata;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pio_switch_led_ctrl_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_MODE      (EDGE_MODE)
        ) u_chan (
            .clk     (clk_clk),
            .rst_n   (reset_reset_n),
            .pin     (switches_export[i]),
            .level   (level[i]),
            .edge_evt(edge_evt[i])
        );
    end

    assign wdata        = avs_writedata[CHANNELS-1:0];
    assign unused_wdata = ^avs_writedata;
    assign edge_clr     = (avs_write && avs_address == 3'd1) ? wdata : '0;
    assign irq          = |(edge_r & mask_r);

    always_comb begin
        rmux = '0;
        case (avs_address)
            3'd0:    rmux = level;
            3'd1:    rmux = edge_r;
            3'd2:    rmux = mask_r;
            3'd3:    rmux = led_r;
            3'd4:    rmux = mode_r;
            default: rmux = '0;
        endcase
        rd_next                 = '0;
        rd_next[CHANNELS-1:0]   = rmux;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            edge_r       <= '0;
            mask_r       <= '0;
            led_r        <= '0;
            mode_r       <= '0;
            avs_readdata <= '0;
            leds_export  <= '0;
            blink_cnt    <= '0;
            phase        <= 1'b0;
        end else begin
            // A new edge wins over a simultaneous write-1-to-clear
            edge_r <= (edge_r & ~edge_clr) | edge_evt;
            if (avs_write) begin
                case (avs_address)
                    3'd2:    mask_r <= wdata;
                    3'd3:    led_r  <= wdata;
                    3'd4:    mode_r <= wdata;
                    default: ;
                endcase
            end
            if (avs_read)
                avs_readdata <= rd_next;
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            leds_export <= led_r & (~mode_r | {CHANNELS{phase}});
        end
    end
endmodule

// File: tb/tb_pio_switch_led_ctrl.sv
// Directed bench for pio_switch_led_ctrl: reset, debounce timing, edge/irq,
// masking, blink drive and channel-width handling.

module tb_pio_switch_led_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sw;
    logic [31:0] sw32;
    logic [2:0]  sw3;
    logic [3:0]  leds;
    logic [31:0] leds32;
    logic [2:0]  leds3;
    logic [2:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] rdata, rdata32, rdata3;
    logic        irq, irq32, irq3;
    int          cyc;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] v;
    logic [3:0]  exp_led;

    always #5 clk = ~clk;

    // Cycles since last reset release, used for the blink phase expectation
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    pio_switch_led_ctrl #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .BLINK_DIV(8), .EDGE_MODE(2)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .switches_export(sw), .leds_export(leds),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(rdata), .irq(irq));

    pio_switch_led_ctrl #(.CHANNELS(32), .DEBOUNCE_CYCLES(4), .BLINK_DIV(8), .EDGE_MODE(2)) dut32 (
        .clk_clk(clk), .reset_reset_n(rst_n), .switches_export(sw32), .leds_export(leds32),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(rdata32), .irq(irq32));

    pio_switch_led_ctrl #(.CHANNELS(3), .DEBOUNCE_CYCLES(4), .BLINK_DIV(8), .EDGE_MODE(2)) dut3 (
        .clk_clk(clk), .reset_reset_n(rst_n), .switches_export(sw3), .leds_export(leds3),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(rdata3), .irq(irq3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = rdata;
    endtask

    initial begin
        rst_n = 1'b0; sw = '0; sw32 = '0; sw3 = '0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        tick(3);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;

        // Get state non-zero, then reset in the middle of a debounce
        wr(3'd3, 32'hF);
        tick(1);
        chk("pre_leds", 32'(leds), 32'hF);
        rd(3'd3, v); chk("pre_led_rd", v, 32'hF);
        sw = 4'hF;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_leds", 32'(leds), 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        rd(3'd0, v); chk("data_e3", v, 32'h0);
        rd(3'd0, v); chk("data_e4", v, 32'h0);
        rd(3'd0, v); chk("data_e5", v, 32'h0);
        rd(3'd0, v); chk("data_e6", v, 32'hF);
        rd(3'd1, v); chk("edge_all", v, 32'hF);
        chk("irq_nomask", 32'(irq), 32'h0);
        sw = 4'h0;
        tick(8);
        wr(3'd1, 32'hF);
        rd(3'd1, v); chk("edge_clr", v, 32'h0);

        // Glitch shorter than the debounce window
        sw = 4'h1; tick(3); sw = 4'h0; tick(8);
        rd(3'd0, v); chk("glitch_data", v, 32'h0);
        rd(3'd1, v); chk("glitch_edge", v, 32'h0);

        // Accepted level: DATA exactly 6 cycles after the pin, EDGE one later
        wr(3'd2, 32'h1);
        sw = 4'h1;
        tick(4);
        rd(3'd0, v); chk("lat4", v, 32'h0);
        rd(3'd0, v); chk("lat5", v, 32'h0);
        rd(3'd0, v); chk("lat6", v, 32'h1);
        chk("irq_rise", 32'(irq), 32'h1);
        rd(3'd1, v); chk("edge_rise", v, 32'h1);
        chk("irq_after_rd", 32'(irq), 32'h1);
        wr(3'd1, 32'h1);
        chk("irq_clr", 32'(irq), 32'h0);

        // Falling edge lands on the same clock as the clear
        sw = 4'h0;
        tick(6);
        wr(3'd1, 32'h1);
        chk("irq_coincide", 32'(irq), 32'h1);
        rd(3'd1, v); chk("edge_coincide", v, 32'h1);
        wr(3'd1, 32'h0);
        rd(3'd1, v); chk("edge_w0", v, 32'h1);
        wr(3'd1, 32'h1);
        rd(3'd1, v); chk("edge_clr2", v, 32'h0);

        // Masked edge on bit2, then unmask
        wr(3'd2, 32'h0);
        sw = 4'h4;
        tick(10);
        rd(3'd1, v); chk("edge_b2", v, 32'h4);
        chk("irq_masked", 32'(irq), 32'h0);
        wr(3'd2, 32'h4);
        chk("irq_unmask", 32'(irq), 32'h1);
        rd(3'd2, v); chk("mask_rd", v, 32'h4);
        wr(3'd1, 32'h4);
        wr(3'd2, 32'h0);

        wr(3'd0, 32'hF);
        rd(3'd0, v); chk("data_ro", v, 32'h4);
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, v); chk("rsvd", v, 32'h0);

        // Bits 0,2 blink, bits 1,3 steady
        wr(3'd4, 32'h5);
        wr(3'd3, 32'hF);
        tick(1);
        for (int i = 0; i < 20; i++) begin
            exp_led = (((cyc - 1) / 8) % 2 == 1) ? 4'hF : 4'hA;
            chk("blink", 32'(leds), 32'(exp_led));
            tick(1);
        end
        wr(3'd4, 32'h0);
        tick(1);
        chk("static", 32'(leds), 32'hF);

        // Channel width handling
        wr(3'd3, 32'hA5A5_A5A5);
        rd(3'd3, v);
        chk("led_rd4", v, 32'h5);
        chk("led_rd32", rdata32, 32'hA5A5_A5A5);
        chk("led_rd3", rdata3, 32'h5);
        chk("leds32", leds32, 32'hA5A5_A5A5);
        chk("leds3", 32'(leds3), 32'h5);
        wr(3'd3, 32'hFF);
        rd(3'd3, v);
        chk("led_ff4", v, 32'hF);
        chk("led_ff3", rdata3, 32'h7);
        chk("leds3_ff", 32'(leds3), 32'h7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pio_switch_led_ctrl.md
# pio_switch_led_ctrl

Parametrised switch-input / LED-output peripheral with an Avalon-MM slave port, replacing the fixed 4-bit switch and LED PIO pair in the board system. It synchronises and debounces CHANNELS switch inputs, captures edges with a maskable interrupt, and drives CHANNELS LEDs in per-channel static or blink mode. It sits on the system interconnect next to the SDRAM controller and is clocked from the system clock.

## Interface

- CHANNELS, 4, number of switch inputs and LED outputs; legal range 1..32.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a new switch level; minimum 1.
- BLINK_DIV, 25000000, clock cycles per blink half-period; minimum 2.
- EDGE_MODE, 2, edge capture select: 0 = rising, 1 = falling, 2 = both.

- clk_clk  input  1  system clock; all logic on its rising edge.
- reset_reset_n  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- switches_export  input  CHANNELS  raw, asynchronous switch pins.
- leds_export  output  CHANNELS  registered LED drive.
- avs_address  input  3  word address.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data; bits above CHANNELS-1 ignored.
- avs_readdata  output  32  read data; bits above CHANNELS-1 read 0.
- irq  output  1  level interrupt, high while any unmasked edge bit is set.

## Operation

- Register map (word addresses): 0 DATA (RO, debounced switch levels; writes ignored), 1 EDGE (read; write-1-to-clear), 2 IRQMASK (RW), 3 LED (RW), 4 MODE (RW; bit i: 0 = static, 1 = blink), 5–7 reserved (read 0, writes ignored).
- Input path per channel: 2-FF synchroniser -> debouncer. Debouncer holds counter width $clog2(DEBOUNCE_CYCLES+1). While sync value equals debounced value the counter is 0; while it differs the counter increments; when it reaches DEBOUNCE_CYCLES the debounced bit takes the sync value and the counter clears. Any return to the debounced value before that clears the counter (glitch rejected).
- Edge capture: on a debounced transition matching EDGE_MODE, EDGE bit i sets the following cycle and stays set until cleared by write-1. Simultaneous new edge and write-1-clear on the same bit: bit stays set (edge wins). Writing 0 bits has no effect.
- irq = OR over (EDGE & IRQMASK), combinational from registers.
- Blink generator: free-running counter 0..BLINK_DIV-1 shared by all channels; at wrap the phase bit toggles. Phase resets to 0 (LEDs off in blink mode).
- LED drive: leds_export[i] registered from LED[i] & (MODE[i] ? phase : 1).
- All registers, counters, outputs reset to 0: leds_export, avs_readdata, irq, EDGE, IRQMASK, LED, MODE, debounced levels, synchroniser flops, phase. Reset mid-operation aborts any pending debounce and clears captured edges.

## Timing

- Slave has no waitrequest; fixed read latency 1: avs_readdata valid the cycle after avs_read, holds until next read.
- Write takes effect at the clock edge where avs_write is high; leds_export reflects a LED/MODE write one cycle later.
- Read and write in same cycle: not permitted by the interconnect; behaviour undefined.
- Pin-to-DATA latency: 2 (sync) + DEBOUNCE_CYCLES cycles; EDGE and irq one further cycle.
- Reading EDGE does not clear it.
- Blink toggle period: exactly BLINK_DIV cycles per phase, 2*BLINK_DIV per full blink.

## Test plan

- Reset: hold reset_reset_n low mid-debounce with switches_export=4'hF -> all outputs 0, DATA reads 0 after release until 2+DEBOUNCE_CYCLES cycles elapse.
- Debounce (DEBOUNCE_CYCLES=4): drive bit0 high for 3 cycles then low -> DATA stays 0; hold high 4+ cycles -> DATA=0x1 exactly 6 cycles after pin change.
- Edge/irq (EDGE_MODE=2): IRQMASK=0x1, toggle bit0 0->1 -> EDGE=0x1, irq=1; write EDGE=0x1 -> irq=0 next cycle; edge coinciding with clear -> EDGE stays 0x1.
- Mask: IRQMASK=0x0, edge on bit2 -> EDGE=0x4, irq=0; then write IRQMASK=0x4 -> irq=1 same cycle as register update.
- LED modes (BLINK_DIV=8): LED=0xF, MODE=0x5 -> leds_export bits 1,3 steady 1, bits 0,2 toggle every 8 cycles starting off.
- Width (CHANNELS=32): write LED=0xA5A5A5A5 -> read back 0xA5A5A5A5, leds_export matches; CHANNELS=3 write 0xFF -> reads 0x7.
